// File: rtl/counter_0_99.sv
// Two-digit up/down counter with debounced push-buttons, optional 1 Hz-style
// auto-increment, and a one-cycle wrap pulse for cascading.

// One raw button: two-flop synchronizer, stability debouncer, rising-edge pulse.
module counter_0_99_btn #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          deb;
    logic          deb_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_d <= deb;
            pulse <= deb & ~deb_d;
            // Any disagreement must persist DEBOUNCE_CYCLES samples to be accepted.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module counter_0_99 #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TICK_CYCLES     = 50_000_000,
    parameter int unsigned MAX_VAL         = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    input  logic       en_auto,
    output logic [6:0] value,
    output logic       wrap
);
    localparam int unsigned VW = 7;
    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam logic [VW-1:0] MAX_V      = VW'(MAX_VAL);
    localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_CYCLES - 1);

    logic          p_up;
    logic          p_down;
    logic          p_clr;
    logic [TW-1:0] presc_q;
    logic [TW-1:0] presc_d;
    logic          tick_c;
    logic [VW-1:0] value_d;
    logic          wrap_d;

    counter_0_99_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .pulse (p_up)
    );

    counter_0_99_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .pulse (p_down)
    );

    counter_0_99_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clr),
        .pulse (p_clr)
    );

    // Auto-increment prescaler; a clear event restarts the tick period.
    always_comb begin
        tick_c  = 1'b0;
        presc_d = presc_q;
        if (!en_auto || p_clr) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_c  = 1'b1;
        end else begin
            presc_d = presc_q + TW'(1);
        end
    end

    // Button events outrank the tick; simultaneous up+down cancel (and drop the tick).
    always_comb begin
        value_d = value;
        wrap_d  = 1'b0;
        if (p_clr) begin
            value_d = '0;
        end else if (p_up && p_down) begin
            value_d = value;
        end else if (p_up || (!p_down && tick_c)) begin
            if (value >= MAX_V) begin
                value_d = '0;
                wrap_d  = 1'b1;
            end else begin
                value_d = value + VW'(1);
            end
        end else if (p_down) begin
            if (value == '0) begin
                value_d = MAX_V;
                wrap_d  = 1'b1;
            end else begin
                value_d = value - VW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            value   <= '0;
            wrap    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            value   <= value_d;
            wrap    <= wrap_d;
        end
    end
endmodule

// File: tb/tb_counter_0_99.sv
// Directed bench for counter_0_99 with DEBOUNCE_CYCLES=4, TICK_CYCLES=10, MAX_VAL=99.
module tb_counter_0_99;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic       en_auto;
    logic [6:0] value;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    counter_0_99 #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (10),
        .MAX_VAL        (99)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_clr  (btn_clr),
        .en_auto  (en_auto),
        .value    (value),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_up   = v;
            1:       btn_down = v;
            2:       btn_clr  = v;
            default: begin btn_up = v; btn_down = v; end
        endcase
    endtask

    // Clean press: 8 cycles high, 10 cycles low; counts wrap pulses seen.
    task automatic press(input int which, output int wraps);
        wraps = 0;
        set_btn(which, 1'b1);
        repeat (8) begin step(); if (wrap) wraps++; end
        set_btn(which, 1'b0);
        repeat (10) begin step(); if (wrap) wraps++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0; en_auto = 1'b0;
        #12;
        check("rst_value", int'(value), 0);
        check("rst_wrap", int'(wrap), 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Held up button: single increment exactly at edge 8.
        btn_up = 1'b1;
        w = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (wrap) w++;
            if (k == 7)  check("up_edge7", int'(value), 0);
            if (k == 8)  check("up_edge8", int'(value), 1);
            if (k == 20) check("up_held", int'(value), 1);
        end
        btn_up = 1'b0;
        repeat (10) begin step(); if (wrap) w++; end
        check("up_release", int'(value), 1);
        check("up_nowrap", w, 0);

        // Glitches shorter than the debounce window.
        btn_down = 1'b1;
        repeat (3) step();
        btn_down = 1'b0;
        repeat (3) step();
        btn_up = 1'b1;
        step();
        btn_up = 1'b0;
        repeat (12) step();
        check("glitch", int'(value), 1);

        // Up and down together cancel.
        press(3, w);
        check("both_value", int'(value), 1);

        // Clear, then wrap down and back up.
        press(2, w);
        check("clr_value", int'(value), 0);
        press(1, w);
        check("down_wrap_value", int'(value), 99);
        check("down_wrap_pulses", w, 1);
        press(0, w);
        check("up_wrap_value", int'(value), 0);
        check("up_wrap_pulses", w, 1);

        // Auto mode: 100 ticks from 0 wraps back to 0.
        en_auto = 1'b1;
        w = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (wrap) w++;
            if (k == 9)    check("auto_edge9", int'(value), 0);
            if (k == 10)   check("auto_edge10", int'(value), 1);
            if (k == 990)  check("auto_99", int'(value), 99);
            if (k == 1000) check("auto_wrap_value", int'(value), 0);
            if (k == 1000) check("auto_wrap_pulse", int'(wrap), 1);
        end
        step();
        check("auto_wrap_end", int'(wrap), 0);
        check("auto_wrap_count", w, 1);
        repeat (4) step();
        en_auto = 1'b0;
        repeat (20) step();
        check("auto_stop", int'(value), 0);
        en_auto = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9)  check("presc_cleared9", int'(value), 0);
            if (k == 10) check("presc_cleared10", int'(value), 1);
        end
        en_auto = 1'b0;

        // Clear during auto mode at 42 restarts the tick period.
        press(2, w);
        check("clr2_value", int'(value), 0);
        en_auto = 1'b1;
        repeat (420) step();
        check("auto_42", int'(value), 42);
        btn_clr = 1'b1;
        for (int k = 1; k <= 578; k++) begin
            step();
            if (k == 10)  btn_clr = 1'b0;
            if (k == 7)   check("aclr_edge7", int'(value), 42);
            if (k == 8)   check("aclr_edge8", int'(value), 0);
            if (k == 17)  check("aclr_edge17", int'(value), 0);
            if (k == 18)  check("aclr_edge18", int'(value), 1);
            if (k == 578) check("auto_57", int'(value), 57);
        end

        // Asynchronous reset mid-count and mid-debounce.
        en_auto = 1'b0;
        btn_up  = 1'b1;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_value", int'(value), 0);
        check("async_rst_wrap", int'(wrap), 0);
        btn_up = 1'b0;
        step(); step();
        rst_n = 1'b1;
        repeat (20) step();
        check("post_rst_no_event", int'(value), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
